radix_bist_ctrl: RTL and testbench
==================================

Name: radix_bist_ctrl

Overview:
Parametrised BIST controller for the radix-4 multiplier, generalising the 8-bit BIST wrapper to WIDTH-bit operands. It provides a proper run/compare flow:
- sequences a programmable number of LFSR patterns through the multiplier using a start/ready handshake;
- compacts results in a MISR and compares the final signature against a golden value;
- reports pass/fail plus timeout errors.

In user mode the multiplier interface passes straight through. The multiplier stays an external instance wired to the mul_* ports.

Parameters:
WIDTH, 8, operand width; product width is 2*WIDTH
PATTERNS, 256, number of patterns per run (1..2^16-1)
LFSR_TAPS, 8'hB8, Galois tap mask for both operand LFSRs (WIDTH bits)
SEED_X, 8'h01, x-LFSR seed (non-zero)
SEED_Y, 8'h5A, y-LFSR seed (non-zero)
MISR_TAPS, 16'hB400, MISR tap mask (2*WIDTH bits)
MISR_SEED, 16'h0000, MISR initial value
GOLDEN_SIG, 16'h0000, expected final signature
TIMEOUT, 64, maximum cycles from mul_start to mul_ready

Ports:
clk  in  1  system clock; all logic on the rising edge
reset_n  in  1  synchronous, active-low reset
active_test  in  1  1 = BIST mode, 0 = user pass-through
bist_run  in  1  one-cycle pulse that starts a BIST run (ignored unless active_test=1 and state is IDLE/DONE)
user_x, user_y  in  WIDTH  user operands
user_start, user_reset  in  1  user multiplier controls
mul_x, mul_y  out  WIDTH  operands to the multiplier
mul_start, mul_reset  out  1  multiplier controls
mul_result  in  2*WIDTH  multiplier product
mul_ready  in  1  multiplier done
result  out  2*WIDTH  user mode: mul_result; BIST mode: current signature
ready  out  1  user mode: mul_ready; BIST mode: bist_done
bist_done  out  1  high from DONE entry until the next run or reset
bist_pass  out  1  valid while bist_done; signature==GOLDEN_SIG and no timeout
timeout_err  out  1  sticky; set when a pattern exceeds TIMEOUT
pattern_cnt  out  16  patterns compacted so far

Behaviour:
Reset (reset_n=0 at a rising edge):
- FSM goes to IDLE; LFSRs load SEED_X/SEED_Y; MISR loads MISR_SEED.
- pattern_cnt=0; bist_done, bist_pass, timeout_err = 0; mul_start=0; mul_reset=1 in BIST mode.
- Reset mid-run aborts with no partial result kept.

Mode mux:
- Purely combinational on active_test.
- When active_test=0, mul_* = user_*, result=mul_result, ready=mul_ready, and the FSM is forced to IDLE on the next edge.

FSM:
- IDLE: mul_reset=1. On bist_run, reload seeds/MISR, clear counters and flags, go to CLR.
- CLR: mul_reset=1 for one cycle, then LAUNCH.
- LAUNCH: mul_reset=0, mul_start=1 for exactly one cycle with mul_x=lfsr_x and mul_y=lfsr_y held stable. Clear the timeout counter, go to WAIT.
- WAIT: operands held. The timeout counter increments every cycle.
  - If mul_ready=1: go to COMPACT.
  - Else if the counter reaches TIMEOUT-1: set timeout_err and go to DONE.
  - A mul_ready and the timeout limit in the same cycle counts as ready.
- COMPACT (1 cycle):
  - misr <= ((misr>>1) ^ (misr[0] ? MISR_TAPS : 0)) ^ mul_result.
  - Each LFSR <= (s>>1) ^ (s[0] ? LFSR_TAPS : 0).
  - pattern_cnt += 1.
  - If the new pattern_cnt == PATTERNS, go to DONE; else go to CLR.
- DONE: bist_done=1; bist_pass = (misr==GOLDEN_SIG) && !timeout_err, registered on entry. A new bist_run restarts exactly as from IDLE.

Per-pattern latency: 3 cycles plus the multiplier latency. pattern_cnt saturates at PATTERNS. The first pattern uses the seed values. bist_run while busy is ignored.

Decomposition:
- Package radix_bist_pkg holds the FSM state enum (IDLE, CLR, LAUNCH, WAIT, COMPACT, DONE) and lfsr_next/misr_next functions parametrised by width and taps.
- One natural sub-module, bist_lfsr (WIDTH, TAPS, SEED; load, advance). It is instantiated twice; the MISR stays inline.

Test Plan:
1. PATTERNS=1, SEED_X=SEED_Y=8'h01, MISR_SEED=0, behavioural multiplier (ready 4 cycles after start) -> mul_x=mul_y=8'h01 at LAUNCH, signature 16'h0001, pattern_cnt=1, bist_done=1.
2. PATTERNS=2, same seeds -> second operands 8'hB8/8'hB8, product 16'h8440, final signature 16'h3040; with GOLDEN_SIG=16'h3040, bist_pass=1; with GOLDEN_SIG=16'h3041, bist_pass=0.
3. Multiplier stub that never raises ready, TIMEOUT=64 -> timeout_err=1 exactly 64 cycles after mul_start, bist_done=1, bist_pass=0, pattern_cnt=0.
4. reset_n=0 for one edge in the middle of pattern 100 of 256 -> next cycle shows IDLE outputs (pattern_cnt=0, bist_done=0, mul_start=0); a rerun gives the same signature as an uninterrupted run.
5. active_test=0, user_x=8'd13, user_y=8'd11, user_start pulse -> mul_* mirror the user inputs, result=16'd143 when ready=1; a bist_run pulse has no effect.
6. WIDTH=16, MISR_TAPS=32'h80200003, PATTERNS=1000 -> run completes, pattern_cnt=1000; the signature matches the reference-model value and is repeatable over two back-to-back runs.

Source files
------------

// File: rtl/radix_bist_pkg.sv
// Shared types and next-state helpers for the radix-4 multiplier BIST controller.
// The helpers work on a wide vector, so callers of any width up to MAXW just cast in and out.
package radix_bist_pkg;

    localparam int unsigned MAXW = 64;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LAUNCH,
        S_WAIT,
        S_COMPACT,
        S_DONE
    } bist_state_e;

    // Galois right-shift step; the taps value must fit within the caller's width.
    function automatic logic [MAXW-1:0] lfsr_next(input logic [MAXW-1:0] s,
                                                  input logic [MAXW-1:0] taps);
        return (s >> 1) ^ (s[0] ? taps : '0);
    endfunction

    function automatic logic [MAXW-1:0] misr_next(input logic [MAXW-1:0] s,
                                                  input logic [MAXW-1:0] taps,
                                                  input logic [MAXW-1:0] data);
        return lfsr_next(s, taps) ^ data;
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Galois LFSR operand generator: loads SEED on reset or load_i, steps on advance_i.
module bist_lfsr
    import radix_bist_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             advance_i,
    output logic [WIDTH-1:0] state_o
);

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;

    assign lfsr_d  = WIDTH'(lfsr_next(MAXW'(lfsr_q), MAXW'(TAPS)));
    assign state_o = lfsr_q;

    always_ff @(posedge clk) begin
        if (!reset_n || load_i) begin
            lfsr_q <= SEED;
        end else if (advance_i) begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/radix_bist_ctrl.sv
// BIST controller for a WIDTH-bit radix-4 multiplier: LFSR patterns, MISR compaction,
// golden-signature compare and per-pattern timeout. active_test=0 passes the user side through.
//
//   state   | meaning
//   IDLE    | waiting for bist_run, multiplier held in reset
//   CLR     | one-cycle multiplier reset before each pattern
//   LAUNCH  | one-cycle mul_start with current LFSR operands
//   WAIT    | waiting for mul_ready, timeout counter running
//   COMPACT | fold product into MISR, step LFSRs, count pattern
//   DONE    | run finished, bist_pass/timeout_err valid
module radix_bist_ctrl
    import radix_bist_pkg::*;
#(
    parameter int unsigned        WIDTH      = 8,
    parameter int unsigned        PATTERNS   = 256,
    parameter logic [WIDTH-1:0]   LFSR_TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0]   SEED_X     = 8'h01,
    parameter logic [WIDTH-1:0]   SEED_Y     = 8'h5A,
    parameter logic [2*WIDTH-1:0] MISR_TAPS  = 16'hB400,
    parameter logic [2*WIDTH-1:0] MISR_SEED  = 16'h0000,
    parameter logic [2*WIDTH-1:0] GOLDEN_SIG = 16'h0000,
    parameter int unsigned        TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               active_test,
    input  logic               bist_run,
    input  logic [WIDTH-1:0]   user_x,
    input  logic [WIDTH-1:0]   user_y,
    input  logic               user_start,
    input  logic               user_reset,
    output logic [WIDTH-1:0]   mul_x,
    output logic [WIDTH-1:0]   mul_y,
    output logic               mul_start,
    output logic               mul_reset,
    input  logic [2*WIDTH-1:0] mul_result,
    input  logic               mul_ready,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               bist_done,
    output logic               bist_pass,
    output logic               timeout_err,
    output logic [15:0]        pattern_cnt
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    bist_state_e   state_q;
    logic [PW-1:0] misr_q, misr_d;
    logic [15:0]   pat_cnt_q, pat_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          done_q, pass_q, terr_q;
    logic          start_q, mreset_q;
    logic          lfsr_load, lfsr_adv;
    logic [WIDTH-1:0] lfsr_x, lfsr_y;

    assign lfsr_load = active_test && bist_run && (state_q == S_IDLE || state_q == S_DONE);
    assign lfsr_adv  = active_test && (state_q == S_COMPACT);
    assign misr_d    = PW'(misr_next(MAXW'(misr_q), MAXW'(MISR_TAPS), MAXW'(mul_result)));
    assign pat_cnt_d = pat_cnt_q + 16'd1;
    assign to_cnt_d  = to_cnt_q + TW'(1);

    bist_lfsr #(.WIDTH(WIDTH), .TAPS(LFSR_TAPS), .SEED(SEED_X)) u_lfsr_x (
        .clk(clk), .reset_n(reset_n), .load_i(lfsr_load), .advance_i(lfsr_adv), .state_o(lfsr_x)
    );

    bist_lfsr #(.WIDTH(WIDTH), .TAPS(LFSR_TAPS), .SEED(SEED_Y)) u_lfsr_y (
        .clk(clk), .reset_n(reset_n), .load_i(lfsr_load), .advance_i(lfsr_adv), .state_o(lfsr_y)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            misr_q    <= MISR_SEED;
            pat_cnt_q <= '0;
            to_cnt_q  <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            terr_q    <= 1'b0;
            start_q   <= 1'b0;
            mreset_q  <= 1'b1;
        end else if (!active_test) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            mreset_q <= 1'b1;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    mreset_q <= 1'b1;
                    if (bist_run) begin
                        state_q   <= S_CLR;
                        misr_q    <= MISR_SEED;
                        pat_cnt_q <= '0;
                        done_q    <= 1'b0;
                        pass_q    <= 1'b0;
                        terr_q    <= 1'b0;
                    end
                end
                S_CLR: begin
                    state_q  <= S_LAUNCH;
                    start_q  <= 1'b1;
                    mreset_q <= 1'b0;
                end
                S_LAUNCH: begin
                    state_q  <= S_WAIT;
                    to_cnt_q <= '0;
                end
                S_WAIT: begin
                    to_cnt_q <= to_cnt_d;
                    // ready wins over a simultaneous timeout
                    if (mul_ready) begin
                        state_q <= S_COMPACT;
                    end else if (to_cnt_d == TW'(TIMEOUT - 1)) begin
                        state_q  <= S_DONE;
                        terr_q   <= 1'b1;
                        done_q   <= 1'b1;
                        pass_q   <= 1'b0;
                        mreset_q <= 1'b1;
                    end
                end
                S_COMPACT: begin
                    misr_q    <= misr_d;
                    pat_cnt_q <= pat_cnt_d;
                    mreset_q  <= 1'b1;
                    if (pat_cnt_d == 16'(PATTERNS)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (misr_d == GOLDEN_SIG) && !terr_q;
                    end else begin
                        state_q <= S_CLR;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        if (active_test) begin
            mul_x     = lfsr_x;
            mul_y     = lfsr_y;
            mul_start = start_q;
            mul_reset = mreset_q;
            result    = misr_q;
            ready     = done_q;
        end else begin
            mul_x     = user_x;
            mul_y     = user_y;
            mul_start = user_start;
            mul_reset = user_reset;
            result    = mul_result;
            ready     = mul_ready;
        end
    end

    assign bist_done   = done_q;
    assign bist_pass   = pass_q;
    assign timeout_err = terr_q;
    assign pattern_cnt = pat_cnt_q;

endmodule

// File: tb/tb_radix_bist_ctrl.sv
// Directed bench for radix_bist_ctrl: five 8-bit instances and one 16-bit instance,
// each with a behavioural multiplier (lane 4 never answers).
module tb_radix_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic rst_n, act, run;
    logic rst3, act3, run3;
    logic [7:0] ux, uy;
    logic ust, urst;

    logic [7:0]  mx [5];
    logic [7:0]  my [5];
    logic [15:0] mres [5];
    logic [15:0] res [5];
    logic [15:0] pc [5];
    logic [4:0]  mst, mrs, mrdy, rdy, done, pass, terr;

    logic [15:0] mxw, myw, pcw;
    logic [31:0] resw;
    logic        mstw, mrsw, rdyw, donew, passw, terrw;
    logic        mrdy_w = 1'b0;
    logic [31:0] mres_w = '0;
    logic        busy_w = 1'b0;
    logic [1:0]  cnt_w  = '0;

    int t0;
    logic [31:0] sig8, sig16;

    radix_bist_ctrl #(.PATTERNS(1), .SEED_X(8'h01), .SEED_Y(8'h01), .GOLDEN_SIG(16'h0001)) u_l0 (
        .clk(clk), .reset_n(rst_n), .active_test(act), .bist_run(run),
        .user_x(8'h00), .user_y(8'h00), .user_start(1'b0), .user_reset(1'b0),
        .mul_x(mx[0]), .mul_y(my[0]), .mul_start(mst[0]), .mul_reset(mrs[0]),
        .mul_result(mres[0]), .mul_ready(mrdy[0]), .result(res[0]), .ready(rdy[0]),
        .bist_done(done[0]), .bist_pass(pass[0]), .timeout_err(terr[0]), .pattern_cnt(pc[0]));

    radix_bist_ctrl #(.PATTERNS(2), .SEED_X(8'h01), .SEED_Y(8'h01), .GOLDEN_SIG(16'h3040)) u_l1 (
        .clk(clk), .reset_n(rst_n), .active_test(act), .bist_run(run),
        .user_x(8'h00), .user_y(8'h00), .user_start(1'b0), .user_reset(1'b0),
        .mul_x(mx[1]), .mul_y(my[1]), .mul_start(mst[1]), .mul_reset(mrs[1]),
        .mul_result(mres[1]), .mul_ready(mrdy[1]), .result(res[1]), .ready(rdy[1]),
        .bist_done(done[1]), .bist_pass(pass[1]), .timeout_err(terr[1]), .pattern_cnt(pc[1]));

    radix_bist_ctrl #(.PATTERNS(2), .SEED_X(8'h01), .SEED_Y(8'h01), .GOLDEN_SIG(16'h3041)) u_l2 (
        .clk(clk), .reset_n(rst_n), .active_test(act), .bist_run(run),
        .user_x(8'h00), .user_y(8'h00), .user_start(1'b0), .user_reset(1'b0),
        .mul_x(mx[2]), .mul_y(my[2]), .mul_start(mst[2]), .mul_reset(mrs[2]),
        .mul_result(mres[2]), .mul_ready(mrdy[2]), .result(res[2]), .ready(rdy[2]),
        .bist_done(done[2]), .bist_pass(pass[2]), .timeout_err(terr[2]), .pattern_cnt(pc[2]));

    radix_bist_ctrl u_l3 (
        .clk(clk), .reset_n(rst3), .active_test(act3), .bist_run(run3),
        .user_x(ux), .user_y(uy), .user_start(ust), .user_reset(urst),
        .mul_x(mx[3]), .mul_y(my[3]), .mul_start(mst[3]), .mul_reset(mrs[3]),
        .mul_result(mres[3]), .mul_ready(mrdy[3]), .result(res[3]), .ready(rdy[3]),
        .bist_done(done[3]), .bist_pass(pass[3]), .timeout_err(terr[3]), .pattern_cnt(pc[3]));

    radix_bist_ctrl u_l4 (
        .clk(clk), .reset_n(rst_n), .active_test(act), .bist_run(run),
        .user_x(8'h00), .user_y(8'h00), .user_start(1'b0), .user_reset(1'b0),
        .mul_x(mx[4]), .mul_y(my[4]), .mul_start(mst[4]), .mul_reset(mrs[4]),
        .mul_result(mres[4]), .mul_ready(mrdy[4]), .result(res[4]), .ready(rdy[4]),
        .bist_done(done[4]), .bist_pass(pass[4]), .timeout_err(terr[4]), .pattern_cnt(pc[4]));

    radix_bist_ctrl #(.WIDTH(16), .PATTERNS(1000), .LFSR_TAPS(16'hB400), .SEED_X(16'h0001),
                      .SEED_Y(16'hACE1), .MISR_TAPS(32'h80200003), .MISR_SEED(32'h0),
                      .GOLDEN_SIG(32'h0), .TIMEOUT(64)) u_w (
        .clk(clk), .reset_n(rst_n), .active_test(act), .bist_run(run),
        .user_x(16'h0000), .user_y(16'h0000), .user_start(1'b0), .user_reset(1'b0),
        .mul_x(mxw), .mul_y(myw), .mul_start(mstw), .mul_reset(mrsw),
        .mul_result(mres_w), .mul_ready(mrdy_w), .result(resw), .ready(rdyw),
        .bist_done(donew), .bist_pass(passw), .timeout_err(terrw), .pattern_cnt(pcw));

    // Multiplier models: product valid and ready raised on the 4th edge after start
    for (genvar g = 0; g < 5; g++) begin : g_mul
        logic        busy  = 1'b0;
        logic [1:0]  cnt   = '0;
        logic        rdy_q = 1'b0;
        logic [15:0] p_q   = '0;
        always @(posedge clk) begin
            if (mrs[g]) begin
                busy  <= 1'b0;
                rdy_q <= 1'b0;
            end else if (mst[g]) begin
                busy  <= 1'b1;
                cnt   <= 2'd2;
                rdy_q <= 1'b0;
                p_q   <= 16'(mx[g]) * 16'(my[g]);
            end else if (busy) begin
                if (cnt == 2'd0) begin
                    busy  <= 1'b0;
                    rdy_q <= (g != 4);
                end else begin
                    cnt <= cnt - 2'd1;
                end
            end
        end
        assign mrdy[g] = rdy_q;
        assign mres[g] = p_q;
    end

    always @(posedge clk) begin
        if (mrsw) begin
            busy_w <= 1'b0;
            mrdy_w <= 1'b0;
        end else if (mstw) begin
            busy_w <= 1'b1;
            cnt_w  <= 2'd2;
            mrdy_w <= 1'b0;
            mres_w <= 32'(mxw) * 32'(myw);
        end else if (busy_w) begin
            if (cnt_w == 2'd0) begin
                busy_w <= 1'b0;
                mrdy_w <= 1'b1;
            end else begin
                cnt_w <= cnt_w - 2'd1;
            end
        end
    end

    function automatic logic [31:0] model_sig(input int n, input logic [15:0] sx,
                                              input logic [15:0] sy, input logic [15:0] taps,
                                              input logic [31:0] mtaps);
        logic [15:0] x;
        logic [15:0] y;
        logic [31:0] m;
        x = sx;
        y = sy;
        m = '0;
        for (int i = 0; i < n; i++) begin
            m = ((m >> 1) ^ (m[0] ? mtaps : 32'h0)) ^ (32'(x) * 32'(y));
            x = (x >> 1) ^ (x[0] ? taps : 16'h0);
            y = (y >> 1) ^ (y[0] ? taps : 16'h0);
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        sig8  = model_sig(256, 16'h0001, 16'h005A, 16'h00B8, 32'h0000B400);
        sig16 = model_sig(1000, 16'h0001, 16'hACE1, 16'hB400, 32'h80200003);
        rst_n = 1'b0; act = 1'b1; run = 1'b0;
        rst3 = 1'b0; act3 = 1'b1; run3 = 1'b0;
        ux = '0; uy = '0; ust = 1'b0; urst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_pc",    32'(pc[0]), 32'h0);
        check("rst_done",  32'(done[0]), 32'h0);
        check("rst_start", 32'(mst[0]), 32'h0);
        check("rst_mreset", 32'(mrs[0]), 32'h1);
        check("rst_sig",   32'(res[0]), 32'h0);
        check("rst_terr",  32'(terr[4]), 32'h0);
        rst_n = 1'b1; rst3 = 1'b1;
        @(negedge clk);

        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int k = 0; k < 20 && mst[0] !== 1'b1; k++) @(negedge clk);
        t0 = cyc;
        check("launch_seen", 32'(mst[0]), 32'h1);
        check("p1_x", 32'(mx[0]), 32'h01);
        check("p1_y", 32'(my[0]), 32'h01);
        check("to_launch", 32'(mst[4]), 32'h1);
        check("to_seed_y", 32'(my[4]), 32'h5A);

        for (int k = 0; k < 40 && pc[1] !== 16'd1; k++) @(negedge clk);
        for (int k = 0; k < 20 && mst[1] !== 1'b1; k++) @(negedge clk);
        check("p2_launch", 32'(mst[1]), 32'h1);
        check("p2_x", 32'(mx[1]), 32'hB8);
        check("p2_y", 32'(my[1]), 32'hB8);

        for (int k = 0; k < 100 && terr[4] !== 1'b1; k++) @(negedge clk);
        check("to_err",     32'(terr[4]), 32'h1);
        check("to_latency", 32'(cyc - t0), 32'd64);
        check("to_done",    32'(done[4]), 32'h1);
        check("to_pass",    32'(pass[4]), 32'h0);
        check("to_pc",      32'(pc[4]), 32'h0);

        for (int k = 0; k < 9000 && donew !== 1'b1; k++) @(negedge clk);
        check("w_done", 32'(donew), 32'h1);
        check("w_pc",   32'(pcw), 32'd1000);
        check("w_sig",  resw, sig16);
        check("w_ready", 32'(rdyw), 32'h1);
        check("w_pass", 32'(passw), 32'(sig16 == 32'h0));
        check("w_terr", 32'(terrw), 32'h0);
        check("t1_sig",  32'(res[0]), 32'h0001);
        check("t1_pc",   32'(pc[0]), 32'h1);
        check("t1_done", 32'(done[0]), 32'h1);
        check("t1_ready", 32'(rdy[0]), 32'h1);
        check("t1_pass", 32'(pass[0]), 32'h1);
        check("t1_start_idle", 32'(mst[0]), 32'h0);
        check("t2_sig",  32'(res[1]), 32'h3040);
        check("t2_pc",   32'(pc[1]), 32'h2);
        check("t2_pass", 32'(pass[1]), 32'h1);
        check("t2b_sig", 32'(res[2]), 32'h3040);
        check("t2b_pass", 32'(pass[2]), 32'h0);
        check("t2b_done", 32'(done[2]), 32'h1);

        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("rerun_done", 32'(done[0]), 32'h0);
        check("rerun_pc",   32'(pc[1]), 32'h0);
        check("rerun_terr", 32'(terr[4]), 32'h0);
        check("rerun_wdone", 32'(donew), 32'h0);
        for (int k = 0; k < 9000 && donew !== 1'b1; k++) @(negedge clk);
        check("w2_done", 32'(donew), 32'h1);
        check("w2_pc",   32'(pcw), 32'd1000);
        check("w2_sig",  resw, sig16);

        run3 = 1'b1;
        @(negedge clk);
        run3 = 1'b0;
        for (int k = 0; k < 1000 && pc[3] !== 16'd99; k++) @(negedge clk);
        for (int k = 0; k < 20 && mst[3] !== 1'b1; k++) @(negedge clk);
        check("mid_pc", 32'(pc[3]), 32'd99);
        repeat (2) @(negedge clk);
        rst3 = 1'b0;
        @(negedge clk);
        rst3 = 1'b1;
        check("abort_pc",    32'(pc[3]), 32'h0);
        check("abort_done",  32'(done[3]), 32'h0);
        check("abort_start", 32'(mst[3]), 32'h0);
        check("abort_mreset", 32'(mrs[3]), 32'h1);
        check("abort_sig",   32'(res[3]), 32'h0);
        @(negedge clk);
        run3 = 1'b1;
        @(negedge clk);
        run3 = 1'b0;
        for (int k = 0; k < 3000 && done[3] !== 1'b1; k++) @(negedge clk);
        check("full_done", 32'(done[3]), 32'h1);
        check("full_pc",   32'(pc[3]), 32'd256);
        check("full_sig",  32'(res[3]), sig8);
        check("full_pass", 32'(pass[3]), 32'(sig8 == 32'h0));

        act3 = 1'b0; ux = 8'd13; uy = 8'd11; ust = 1'b1; urst = 1'b0;
        #1;
        check("user_x", 32'(mx[3]), 32'd13);
        check("user_y", 32'(my[3]), 32'd11);
        check("user_start", 32'(mst[3]), 32'h1);
        check("user_mreset", 32'(mrs[3]), 32'h0);
        @(negedge clk);
        ust = 1'b0;
        run3 = 1'b1;
        @(negedge clk);
        run3 = 1'b0;
        for (int k = 0; k < 20 && rdy[3] !== 1'b1; k++) @(negedge clk);
        check("user_ready",  32'(rdy[3]), 32'h1);
        check("user_result", 32'(res[3]), 32'd143);
        check("user_run_ignored", 32'(pc[3]), 32'd256);
        check("user_no_start", 32'(mst[3]), 32'h0);
        act3 = 1'b1;
        repeat (3) @(negedge clk);
        check("back_no_start", 32'(mst[3]), 32'h0);
        check("back_pc",   32'(pc[3]), 32'd256);
        check("back_done", 32'(done[3]), 32'h1);
        check("back_sig",  32'(res[3]), sig8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
